// File: rtl/i2c_xfer_sequencer.sv
// Wishbone master that walks the iicmb_m_wb core through one complete I2C transfer:
// core enable, optional bus select, START, address, data bytes, STOP, with irq-paced
// CMDR status checks between commands.
module i2c_xfer_sequencer #(
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH      = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [3:0]                req_bus_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_op_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  input  logic                      wr_valid_i,
  input  logic [7:0]                wr_data_i,
  output logic                      wr_ready_o,
  output logic                      rd_valid_o,
  output logic [7:0]                rd_data_o,
  output logic                      done_o,
  output logic [1:0]                err_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  localparam logic [2:0] CmdWrite  = 3'b001;
  localparam logic [2:0] CmdRdAck  = 3'b010;
  localparam logic [2:0] CmdRdNak  = 3'b011;
  localparam logic [2:0] CmdStart  = 3'b100;
  localparam logic [2:0] CmdStop   = 3'b101;
  localparam logic [2:0] CmdSetBus = 3'b110;

  localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

  localparam logic [LEN_WIDTH-1:0] LenZero = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LenOne  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LenTwo  = LEN_WIDTH'(2);

  typedef enum logic [3:0] {
    StInit, StIdle, StBusDpr, StAddrDpr, StWrWait, StWrDpr,
    StCmd, StWaitIrq, StStatus, StRdDpr, StDone
  } state_e;

  state_e                    state_q, state_d;
  logic                      cyc_q, cyc_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [2:0]                cmd_q, cmd_d;
  logic [3:0]                bus_q, bus_d, cache_bus_q, cache_bus_d;
  logic                      cache_ok_q, cache_ok_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      op_q, op_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [7:0]                byte_q, byte_d, rd_data_q, rd_data_d;
  logic [1:0]                err_q, err_d;
  logic                      rd_valid_q, rd_valid_d;

  // Per-state bus access request; the shared tail turns it into one WB cycle.
  logic                      acc_req, acc_we, acc_done;
  logic [WB_ADDR_WIDTH-1:0]  acc_adr;
  logic [WB_DATA_WIDTH-1:0]  acc_dat;

  // State register and datapath registers; reset abandons any bus cycle without a STOP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cmd_q       <= 3'b000;
      bus_q       <= 4'h0;
      cache_bus_q <= 4'h0;
      cache_ok_q  <= 1'b0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      cnt_q       <= '0;
      byte_q      <= 8'h00;
      rd_data_q   <= 8'h00;
      err_q       <= 2'b00;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cmd_q       <= cmd_d;
      bus_q       <= bus_d;
      cache_bus_q <= cache_bus_d;
      cache_ok_q  <= cache_ok_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Next-state, bus access sequencing and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cmd_d       = cmd_q;
    bus_d       = bus_q;
    cache_bus_d = cache_bus_q;
    cache_ok_d  = cache_ok_q;
    addr_d      = addr_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    rd_valid_d  = 1'b0;
    acc_req     = 1'b0;
    acc_we      = 1'b0;
    acc_adr     = '0;
    acc_dat     = '0;
    acc_done    = cyc_q & ack_i;
    req_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    done_o      = 1'b0;
    err_o       = 2'b00;

    case (state_q)
      StInit: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrCsr;
        acc_dat = WB_DATA_WIDTH'(8'hC0);
        if (acc_done) state_d = StIdle;
      end
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          bus_d  = req_bus_i;
          addr_d = req_addr_i;
          op_d   = req_op_i;
          cnt_d  = req_len_i;
          err_d  = 2'b00;
          if (cache_ok_q && (cache_bus_q == req_bus_i)) begin
            cmd_d   = CmdStart;
            state_d = StCmd;
          end else begin
            state_d = StBusDpr;
          end
        end
      end
      StBusDpr: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrDpr;
        acc_dat = WB_DATA_WIDTH'(bus_q);
        if (acc_done) begin
          cmd_d   = CmdSetBus;
          state_d = StCmd;
        end
      end
      StAddrDpr: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrDpr;
        acc_dat = WB_DATA_WIDTH'({addr_q, op_q});
        if (acc_done) begin
          cmd_d   = CmdWrite;
          state_d = StCmd;
        end
      end
      StWrWait: begin
        wr_ready_o = wr_valid_i;
        if (wr_valid_i) begin
          byte_d  = wr_data_i;
          cnt_d   = (cnt_q != LenZero) ? cnt_q - LenOne : cnt_q;
          state_d = StWrDpr;
        end
      end
      StWrDpr: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrDpr;
        acc_dat = WB_DATA_WIDTH'(byte_q);
        if (acc_done) begin
          cmd_d   = CmdWrite;
          state_d = StCmd;
        end
      end
      StCmd: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrCmdr;
        acc_dat = WB_DATA_WIDTH'(cmd_q);
        if (acc_done) state_d = StWaitIrq;
      end
      StWaitIrq: begin
        if (irq_i) state_d = StStatus;
      end
      StStatus: begin
        // Reading CMDR also clears the core's irq.
        acc_req = 1'b1;
        acc_adr = AdrCmdr;
        if (acc_done) begin
          if (dat_i[4] || dat_i[5]) begin
            err_d      = dat_i[4] ? 2'b11 : 2'b10;
            cache_ok_d = 1'b0;
            state_d    = StDone;
          end else if (dat_i[6] && (cmd_q != CmdStop)) begin
            err_d   = 2'b01;
            cmd_d   = CmdStop;
            state_d = StCmd;
          end else begin
            case (cmd_q)
              CmdSetBus: begin
                cache_bus_d = bus_q;
                cache_ok_d  = 1'b1;
                cmd_d       = CmdStart;
                state_d     = StCmd;
              end
              CmdStart: state_d = StAddrDpr;
              CmdWrite: begin
                // Counter already reflects bytes still owed after this WRITE.
                if (cnt_q == LenZero) begin
                  cmd_d   = CmdStop;
                  state_d = StCmd;
                end else if (op_q) begin
                  cmd_d   = (cnt_q == LenOne) ? CmdRdNak : CmdRdAck;
                  state_d = StCmd;
                end else begin
                  state_d = StWrWait;
                end
              end
              CmdRdAck, CmdRdNak: state_d = StRdDpr;
              default: state_d = StDone;
            endcase
          end
        end
      end
      StRdDpr: begin
        acc_req = 1'b1;
        acc_adr = AdrDpr;
        if (acc_done) begin
          rd_valid_d = 1'b1;
          rd_data_d  = dat_i[7:0];
          cnt_d      = (cnt_q != LenZero) ? cnt_q - LenOne : cnt_q;
          cmd_d      = (cnt_q == LenOne) ? CmdStop : ((cnt_q == LenTwo) ? CmdRdNak : CmdRdAck);
          state_d    = StCmd;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Launch on the first cycle of an access state; drop everything the cycle after ack.
    if (acc_req && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end
    if (acc_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end
  end

  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign we_o       = we_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Bench for i2c_xfer_sequencer: iicmb-like Wishbone slave with injectable status faults,
// a byte-stream source/sink, and a transfer-level model of the expected bus traffic.
module tb_i2c_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_op;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [5:0] req_len;
  logic       wr_valid, wr_ready, rd_valid, done;
  logic [7:0] wr_data, rd_data;
  logic [1:0] err;
  logic       cyc, stb, we, ack, irq;
  logic [1:0] adr;
  logic [7:0] dat_o, dat_i;

  always #5 clk = ~clk;

  i2c_xfer_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
    .req_addr_i(req_addr), .req_op_i(req_op), .req_len_i(req_len),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .done_o(done), .err_o(err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] wb_log[$];
  logic [10:0] exp_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  wbytes[64];
  logic [7:0]  rd_src[64];
  logic [1:0]  exp_err, last_err;
  int          wr_idx, wr_len, done_cnt;
  bit          consumed;
  int          fault_idx = -1;
  logic [7:0]  fault_status = 8'h80;
  int          cmd_no, rd_pos, irq_cnt, wait_cnt;
  logic [7:0]  cur_status;
  bit          mc_valid = 1'b0;
  logic [3:0]  mc_bus = 4'h0;
  logic [7:0]  stat_tab[7] = '{8'h40, 8'hC0, 8'h20, 8'h60, 8'h10, 8'h30, 8'h70};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: random ack latency, irq some cycles after each CMDR write, status on CMDR read.
  initial begin
    ack = 1'b0; irq = 1'b0; dat_i = 8'h00; wait_cnt = 0; irq_cnt = 0;
    cmd_no = 0; rd_pos = 0; cur_status = 8'h80;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack = 1'b0; irq = 1'b0; irq_cnt = 0; wait_cnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq = 1'b1;
        end
        if (ack) ack = 1'b0;
        else if (cyc && stb) begin
          if (wait_cnt > 0) wait_cnt--;
          else begin
            ack   = 1'b1;
            dat_i = 8'($urandom);
            wb_log.push_back({we, adr, we ? dat_o : 8'h00});
            if (we && adr == 2'd2) begin
              cur_status = (cmd_no == fault_idx && dat_o[2:0] != 3'b101) ? fault_status : 8'h80;
              cmd_no++;
              irq_cnt = $urandom_range(1, 4);
            end else if (!we && adr == 2'd2) begin
              dat_i = cur_status;
              irq   = 1'b0;
            end else if (!we && adr == 2'd1) begin
              dat_i = rd_src[rd_pos % 64];
              rd_pos++;
            end
            wait_cnt = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  // Write-byte source with random idle gaps.
  initial begin
    wr_valid = 1'b0; wr_data = 8'h00; consumed = 1'b0; wr_idx = 0; wr_len = 0;
    forever begin
      @(negedge clk);
      if (consumed) wr_idx++;
      if (!rst && wr_idx < wr_len && $urandom_range(0, 3) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wbytes[wr_idx];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
      #1 consumed = wr_valid && wr_ready;
    end
  end

  // Read-byte and completion monitor.
  initial begin
    done_cnt = 0; last_err = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid) rd_log.push_back(rd_data);
        if (done) begin
          done_cnt++;
          last_err = err;
        end
      end
    end
  end

  // One command on the core: CMDR write, then CMDR read; returns the error class it produces.
  task automatic model_cmd(input logic [2:0] code, inout int ci, output logic [1:0] res);
    logic [7:0] st;
    exp_log.push_back({1'b1, 2'd2, 5'b0, code});
    exp_log.push_back({1'b0, 2'd2, 8'h00});
    st = (ci == fault_idx && code != 3'b101) ? fault_status : 8'h80;
    ci++;
    if (st[4]) res = 2'b11;
    else if (st[5]) res = 2'b10;
    else if (st[6]) res = 2'b01;
    else res = 2'b00;
  endtask

  // Expected Wishbone traffic, read bytes and status for one whole transfer.
  task automatic model_xfer(input logic [3:0] bus, input logic [6:0] addr, input bit op,
                            input int len);
    int         ci = 0;
    logic [1:0] res = 2'b00;
    logic [1:0] ignored;
    exp_log.delete();
    exp_rd.delete();
    if (!(mc_valid && mc_bus == bus)) begin
      exp_log.push_back({1'b1, 2'd1, 4'h0, bus});
      model_cmd(3'b110, ci, res);
      if (res == 2'b00) begin
        mc_valid = 1'b1;
        mc_bus   = bus;
      end
    end
    if (res == 2'b00) model_cmd(3'b100, ci, res);
    if (res == 2'b00) begin
      exp_log.push_back({1'b1, 2'd1, addr, op});
      model_cmd(3'b001, ci, res);
    end
    for (int i = 0; i < len && res == 2'b00; i++) begin
      if (!op) begin
        exp_log.push_back({1'b1, 2'd1, wbytes[i]});
        model_cmd(3'b001, ci, res);
      end else begin
        model_cmd((i == len - 1) ? 3'b011 : 3'b010, ci, res);
        if (res == 2'b00) begin
          exp_log.push_back({1'b0, 2'd1, 8'h00});
          exp_rd.push_back(rd_src[i]);
        end
      end
    end
    if (res <= 2'b01) model_cmd(3'b101, ci, ignored);
    else mc_valid = 1'b0;
    exp_err = res;
  endtask

  task automatic send_req(input string tag, input logic [3:0] bus, input logic [6:0] addr,
                          input bit op, input int len);
    int t = 0;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_bus = bus; req_addr = addr; req_op = op; req_len = 6'(len);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, " ready drops"}, 32'(req_ready), 32'd0);
  endtask

  task automatic run_xfer(input string tag, input logic [3:0] bus, input logic [6:0] addr,
                          input bit op, input int len, input int fidx, input logic [7:0] fst);
    int t = 0;
    int n;
    fault_idx = fidx; fault_status = fst; cmd_no = 0; rd_pos = 0;
    wb_log.delete(); rd_log.delete(); done_cnt = 0;
    model_xfer(bus, addr, op, len);
    wr_idx = 0;
    wr_len = op ? 0 : len;
    send_req(tag, bus, addr, op, len);
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, " err"}, 32'(last_err), 32'(exp_err));
    check_eq({tag, " wb count"}, 32'(wb_log.size()), 32'(exp_log.size()));
    n = (wb_log.size() < exp_log.size()) ? wb_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s wb[%0d]", tag, i), 32'(wb_log[i]), 32'(exp_log[i]));
    check_eq({tag, " rd count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s rd[%0d]", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
  endtask

  // Waits for the core-enable write after reset and checks ready only follows its ack.
  task automatic check_init(input string tag);
    int t = 0;
    while (wb_log.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, " first op"}, (wb_log.size() > 0) ? 32'(wb_log[0]) : 32'hFFFF,
             32'({1'b1, 2'd0, 8'hC0}));
    check_eq({tag, " not ready at ack"}, 32'(req_ready), 32'd0);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, " ready after init"}, 32'(req_ready), 32'd1);
    check_eq({tag, " single init op"}, 32'(wb_log.size()), 32'd1);
  endtask

  initial begin
    int t;
    int len;
    int fidx;
    rst = 1'b1; req_valid = 1'b0; req_bus = 4'h0; req_addr = 7'h00; req_op = 1'b0;
    req_len = 6'd0;
    repeat (3) @(negedge clk);
    check_eq("reset outputs", 32'({req_ready, wr_ready, rd_valid, rd_data, done, err, cyc, stb,
                                   we, adr, dat_o}), 32'd0);
    rst = 1'b0;
    check_init("init");

    for (int i = 0; i < 64; i++) wbytes[i] = 8'(i);
    run_xfer("wr32", 4'd5, 7'h22, 1'b0, 32, -1, 8'h80);
    for (int i = 0; i < 64; i++) rd_src[i] = 8'(100 + i);
    run_xfer("rd32", 4'd5, 7'h22, 1'b1, 32, -1, 8'h80);
    run_xfer("bus2", 4'd2, 7'h22, 1'b0, 3, -1, 8'h80);
    run_xfer("addr_nak", 4'd2, 7'h23, 1'b0, 4, 1, 8'h40);
    run_xfer("probe", 4'd2, 7'h10, 1'b0, 0, -1, 8'h80);
    run_xfer("arb_lost", 4'd2, 7'h22, 1'b0, 5, 3, 8'h20);
    run_xfer("rd_err", 4'd2, 7'h22, 1'b1, 4, 3, 8'h30);
    run_xfer("rd_one", 4'd2, 7'h31, 1'b1, 1, -1, 8'h80);
    for (int i = 0; i < 64; i++) wbytes[i] = 8'($urandom);
    run_xfer("max_len", 4'd3, 7'h55, 1'b0, 63, -1, 8'h80);

    for (int k = 0; k < 30; k++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 63) : $urandom_range(0, 12);
      for (int i = 0; i < 64; i++) begin
        wbytes[i] = 8'($urandom);
        rd_src[i] = 8'($urandom);
      end
      fidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, len + 3);
      run_xfer($sformatf("rnd%0d", k), 4'($urandom_range(0, 3)), 7'($urandom),
               1'($urandom_range(0, 1)), len, fidx, stat_tab[$urandom_range(0, 6)]);
    end

    // Reset in the middle of a 20-byte write, after ten bytes have gone out.
    fault_idx = -1; cmd_no = 0; wr_idx = 0; wr_len = 20;
    send_req("mid_rst", 4'd5, 7'h22, 1'b0, 20);
    t = 0;
    while (!(wr_idx >= 10 && cyc) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_rst reached byte 10", 32'(wr_idx >= 10 && cyc), 32'd1);
    rst = 1'b1; mc_valid = 1'b0; wr_len = 0;
    @(negedge clk);
    check_eq("mid_rst cyc drop", 32'({cyc, stb}), 32'd0);
    @(negedge clk);
    wb_log.delete();
    rst = 1'b0;
    check_init("reinit");
    run_xfer("after_rst", 4'd5, 7'h22, 1'b0, 2, -1, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
